mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and lane-merge helper for mem_access_unit
// Purpose: request-size encodings, the access FSM state type and the
//          store-lane merge used by the read-modify-write path.
// Ports:   none (package).
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_RSP = 2'd1,
        RMW_WR = 2'd2
    } accessState_e;

    // Replace the addressed byte/half lane of oldWord with the low bits of newData.
    function automatic logic [31:0] mergeLane(
        input logic [31:0] oldWord,
        input logic [31:0] newData,
        input logic [1:0]  size,
        input logic [1:0]  offset
    );
        logic [31:0] merged;
        merged = oldWord;
        if (size == SZ_BYTE) begin
            case (offset)
                2'd0:    merged[7:0]   = newData[7:0];
                2'd1:    merged[15:8]  = newData[7:0];
                2'd2:    merged[23:16] = newData[7:0];
                default: merged[31:24] = newData[7:0];
            endcase
        end else begin
            if (offset[1]) merged[31:16] = newData[15:0];
            else           merged[15:0]  = newData[15:0];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane extraction with sign/zero extension
// Purpose: pick the byte/half/word lane out of a memory word and extend it.
// Ports:   word       - raw memory word
//          size       - request size encoding
//          offset     - byte address bits [1:0]
//          isUnsigned - 1 = zero-extend, 0 = sign-extend
//          data       - right-justified, extended result
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        isUnsigned,
    output logic [31:0] data
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        case (offset)
            2'd0:    byteVal = word[7:0];
            2'd1:    byteVal = word[15:8];
            2'd2:    byteVal = word[23:16];
            default: byteVal = word[31:24];
        endcase
        halfVal = offset[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_BYTE: data = {{24{~isUnsigned & byteVal[7]}}, byteVal};
            SZ_HALF: data = {{16{~isUnsigned & halfVal[15]}}, halfVal};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit with sub-word read-modify-write
// Purpose: turns CPU byte/half/word requests into word accesses on a data
//          memory; sub-word stores use a read then a merged write-back.
// Ports:   clock, reset            - clock, async active-high reset
//          req_*                   - CPU request (valid/write/size/unsigned/addr/wdata)
//          stall, ld_valid, ld_data, err - CPU response
//          mem_address, mem_writeData, mem_memWrite, mem_memRead, mem_readData - data memory
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    // 33 bits so the limit itself never wraps for large MEM_WORDS.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    accessState_e state, nextState;
    logic [31:0]  addrQ;
    logic [31:0]  merge_q;
    logic [31:0]  alignedData;
    logic         reqBad;
    logic         accept;
    logic [31:0]  wordAddr;

    mem_load_align u_align (
        .word       (mem_readData),
        .size       (req_size),
        .offset     (req_addr[1:0]),
        .isUnsigned (req_unsigned),
        .data       (alignedData)
    );

    always_comb begin
        wordAddr = {req_addr[31:2], 2'b00};
        reqBad   = (req_size == SZ_ILLEGAL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || ({1'b0, req_addr} >= ADDR_LIMIT);
        accept   = (state == IDLE) && req_valid && !reqBad;
        err      = (state == IDLE) && req_valid && reqBad;
    end

    always_comb begin
        nextState     = state;
        stall         = 1'b0;
        ld_valid      = 1'b0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        mem_address   = wordAddr;
        mem_writeData = req_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_write) begin
                        mem_memRead = 1'b1;
                        stall       = 1'b1;
                        nextState   = LD_RSP;
                    end else if (req_size == SZ_WORD) begin
                        mem_memWrite = 1'b1;
                    end else begin
                        // Sub-word store: fetch the word now, write the merge next cycle.
                        mem_memRead = 1'b1;
                        stall       = 1'b1;
                        nextState   = RMW_WR;
                    end
                end
            end
            LD_RSP: begin
                ld_valid    = 1'b1;
                mem_address = addrQ;
                nextState   = IDLE;
            end
            RMW_WR: begin
                mem_memWrite  = 1'b1;
                mem_writeData = merge_q;
                mem_address   = addrQ;
                nextState     = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addrQ   <= '0;
            merge_q <= '0;
            ld_data <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrQ <= wordAddr;
                if (!req_write) begin
                    ld_data <= alignedData;
                end else if (req_size != SZ_WORD) begin
                    merge_q <= mergeLane(mem_readData, req_wdata, req_size, req_addr[1:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, ld_valid, err, mem_memWrite, mem_memRead;
    logic [31:0] ld_data, mem_address, mem_writeData, mem_readData;

    int compared = 0;
    int mismatched = 0;
    int writeCount = 0;
    int bothCount = 0;
    logic presetReq;

    logic [31:0] mem [0:127];

    always #5 clock = ~clock;

    mem_access_unit #(.MEM_WORDS(128)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData)
    );

    always_comb mem_readData = mem[mem_address[8:2]];

    always @(negedge clock) begin
        if (mem_memWrite && mem_memRead) bothCount = bothCount + 1;
        if (presetReq) begin
            mem[4]   <= 32'h8899AABB;
            mem[5]   <= 32'h00000000;
            mem[127] <= 32'h01234567;
        end else if (mem_memWrite) begin
            mem[mem_address[8:2]] <= mem_writeData;
            writeCount = writeCount + 1;
        end
    end

    typedef struct {
        logic        preset;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic        expStall;
        logic [31:0] expLd;
        int          expWrites;
        logic [31:0] expWord;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic presetMem();
        presetReq = 1'b1;
        @(posedge clock); #1;
        presetReq = 1'b0;
    endtask

    // Entered and left 1 time unit after a posedge with the FSM in IDLE.
    task automatic runVec(input int idx, input vec_t v);
        int wc0;
        logic expRead, expWrite;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.preset) presetMem();
        expRead  = !v.expErr && (!v.wr || v.size != SZ_WORD);
        expWrite = !v.expErr && v.wr && v.size == SZ_WORD;
        req_valid = 1'b1; req_write = v.wr; req_size = v.size;
        req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        wc0 = writeCount;
        #1;
        check({tag, " err"}, 32'(err), 32'(v.expErr));
        check({tag, " stall"}, 32'(stall), 32'(v.expStall));
        check({tag, " memRead"}, 32'(mem_memRead), 32'(expRead));
        check({tag, " memWrite"}, 32'(mem_memWrite), 32'(expWrite));
        if (!v.expErr) check({tag, " addr"}, mem_address, {v.addr[31:2], 2'b00});
        @(posedge clock); #1;
        req_valid = 1'b0;
        #1;
        if (v.expStall && !v.wr) begin
            check({tag, " ld_valid"}, 32'(ld_valid), 32'd1);
            check({tag, " ld_data"}, ld_data, v.expLd);
            check({tag, " rsp stall"}, 32'(stall), 32'd0);
        end else if (v.expStall) begin
            check({tag, " rmw write"}, 32'(mem_memWrite), 32'd1);
            check({tag, " rmw addr"}, mem_address, {v.addr[31:2], 2'b00});
        end else begin
            check({tag, " no ld_valid"}, 32'(ld_valid), 32'd0);
        end
        @(posedge clock); #1;
        check({tag, " ld_valid low"}, 32'(ld_valid), 32'd0);
        check({tag, " writes"}, 32'(writeCount - wc0), 32'(v.expWrites));
        if (v.wr && !v.expErr) check({tag, " word"}, mem[v.addr[8:2]], v.expWord);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wc0;
        vecs[0]  = '{1, 0, SZ_BYTE, 0, 32'h11, 32'h0, 0, 1, 32'hFFFFFFAA, 0, 32'h0};
        vecs[1]  = '{0, 0, SZ_HALF, 1, 32'h12, 32'h0, 0, 1, 32'h00008899, 0, 32'h0};
        vecs[2]  = '{0, 0, SZ_HALF, 0, 32'h12, 32'h0, 0, 1, 32'hFFFF8899, 0, 32'h0};
        vecs[3]  = '{0, 0, SZ_BYTE, 1, 32'h13, 32'h0, 0, 1, 32'h00000088, 0, 32'h0};
        vecs[4]  = '{0, 0, SZ_BYTE, 0, 32'h10, 32'h0, 0, 1, 32'hFFFFFFBB, 0, 32'h0};
        vecs[5]  = '{1, 1, SZ_BYTE, 0, 32'h13, 32'h000000CC, 0, 1, 32'h0, 1, 32'hCC99AABB};
        vecs[6]  = '{1, 1, SZ_HALF, 0, 32'h10, 32'hFFFF1234, 0, 1, 32'h0, 1, 32'h88991234};
        vecs[7]  = '{0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, 1, 32'h88991234, 0, 32'h0};
        vecs[8]  = '{0, 1, SZ_WORD, 0, 32'h06, 32'h11111111, 1, 0, 32'h0, 0, 32'h0};
        vecs[9]  = '{0, 0, SZ_WORD, 0, 32'h200, 32'h0, 1, 0, 32'h0, 0, 32'h0};
        vecs[10] = '{0, 0, SZ_ILLEGAL, 0, 32'h10, 32'h0, 1, 0, 32'h0, 0, 32'h0};
        vecs[11] = '{0, 0, SZ_HALF, 0, 32'h11, 32'h0, 1, 0, 32'h0, 0, 32'h0};
        vecs[12] = '{0, 1, SZ_WORD, 0, 32'h14, 32'hDEADBEEF, 0, 0, 32'h0, 1, 32'hDEADBEEF};
        vecs[13] = '{0, 0, SZ_BYTE, 0, 32'h17, 32'h0, 0, 1, 32'hFFFFFFDE, 0, 32'h0};
        vecs[14] = '{0, 1, SZ_BYTE, 0, 32'h15, 32'h00000077, 0, 1, 32'h0, 1, 32'hDEAD77EF};
        vecs[15] = '{0, 0, SZ_WORD, 0, 32'h1FC, 32'h0, 0, 1, 32'h01234567, 0, 32'h0};
        vecs[16] = '{0, 1, SZ_HALF, 0, 32'h1FE, 32'h0000ABCD, 0, 1, 32'h0, 1, 32'hABCD4567};
        vecs[17] = '{0, 1, SZ_BYTE, 0, 32'h200, 32'h000000EE, 1, 0, 32'h0, 0, 32'h0};

        reset = 1'b1; presetReq = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0; presetReq = 1'b0;
        #1;
        check("reset ld_data", ld_data, 32'h0);
        check("reset ld_valid", 32'(ld_valid), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("idle strobes", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
        check("idle err", 32'(err), 32'd0);
        @(posedge clock); #1;

        for (int i = 0; i < 18; i++) runVec(i, vecs[i]);

        repeat (3) @(posedge clock);
        #1;
        check("ld_data hold", ld_data, 32'h01234567);

        // Reset during RMW_WR must drop the pending write.
        presetMem();
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rmw reached", 32'(mem_memWrite), 32'd1);
        wc0 = writeCount;
        reset = 1'b1;
        #1;
        check("rmw abort write", 32'(mem_memWrite), 32'd0);
        check("rmw abort stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rmw abort writes", 32'(writeCount - wc0), 32'd0);
        check("rmw abort word", mem[4], 32'h8899AABB);
        @(posedge clock); #1;
        runVec(100, '{0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, 1, 32'h8899AABB, 0, 32'h0});

        // Reset during LD_RSP must suppress ld_valid and clear ld_data.
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h14;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("ldrsp reached", 32'(ld_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("ldrsp abort valid", 32'(ld_valid), 32'd0);
        check("ldrsp abort data", ld_data, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("ldrsp after valid", 32'(ld_valid), 32'd0);
        check("both strobes", 32'(bothCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
